// File: rtl/bubble_ctrl.sv
// Pipeline bubble/flush strobe generator with stall watchdog.
// Optional bubble performance counter enabled by defining BUBBLE_PERF_CNT_EN.
module bubble_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bb,
  input  logic             br_taken,
  output logic             hold_s1,
  output logic             hold_s2,
  output logic             nop_s3,
  output logic             flush_s1,
  output logic             flush_s2,
  output logic             stall_err,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int SW = $clog2(MAX_STALL + 1);

  // state | meaning
  // RUN   | normal flow, no bubble outstanding
  // STALL | S1/S2 held and NOP injected into S3 while bb persists
  // FLUSH | wrong-path window after a taken branch, bb masked
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t        state, state_n;
  logic [1:0]    fcnt, fcnt_n;
  logic [SW-1:0] stall_len, stall_len_n;
  logic          err_set;
  logic          strobe_hold, strobe_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fcnt      <= 2'd0;
      stall_len <= '0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      stall_len <= stall_len_n;
      if (err_set) stall_err <= 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    fcnt_n       = fcnt;
    stall_len_n  = stall_len;
    strobe_hold  = 1'b0;
    strobe_flush = 1'b0;
    err_set      = 1'b0;
    if (rst) begin
      state_n     = RUN;
      fcnt_n      = 2'd0;
      stall_len_n = '0;
    end else if (br_taken) begin
      strobe_flush = 1'b1;
      state_n      = FLUSH;
      fcnt_n       = 2'(FLUSH_CYC);
      stall_len_n  = '0;
    end else begin
      case (state)
        RUN: begin
          if (bb) begin
            strobe_hold = 1'b1;
            stall_len_n = SW'(1);
            state_n     = STALL;
          end
        end
        STALL: begin
          if (bb) begin
            strobe_hold = 1'b1;
            if (stall_len != SW'(MAX_STALL)) stall_len_n = stall_len + SW'(1);
            if (({1'b0, stall_len} + (SW+1)'(1)) == (SW+1)'(MAX_STALL)) err_set = 1'b1;
          end else begin
            stall_len_n = '0;
            state_n     = RUN;
          end
        end
        FLUSH: begin
          fcnt_n = fcnt - 2'd1;
          // fcnt==0 cannot occur legally; leave FLUSH rather than wrap
          if (fcnt <= 2'd1) begin
            fcnt_n  = 2'd0;
            state_n = RUN;
          end
        end
        default: begin
          state_n     = RUN;
          fcnt_n      = 2'd0;
          stall_len_n = '0;
        end
      endcase
    end
  end

  assign hold_s1  = strobe_hold;
  assign hold_s2  = strobe_hold;
  assign nop_s3   = strobe_hold;
  assign flush_s1 = strobe_flush;
  assign flush_s2 = strobe_flush;

`ifdef BUBBLE_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, cnt_q};
    if (nop_s3)        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(1);
    else if (flush_s1) cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(2);
  end

  always_ff @(posedge clk) begin
    if (rst)               cnt_q <= '0;
    else if (cnt_sum[CNT_W]) cnt_q <= '1;
    else                   cnt_q <= cnt_sum[CNT_W-1:0];
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_bubble_ctrl.sv
// Directed self-checking bench for bubble_ctrl (FLUSH_CYC=2, MAX_STALL=8, CNT_W=4).
module tb_bubble_ctrl;
  logic       clk = 1'b0;
  logic       rst, bb, br_taken;
  logic       hold_s1, hold_s2, nop_s3, flush_s1, flush_s2, stall_err;
  logic [3:0] bubble_cnt;
  logic [4:0] st;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;

`ifdef BUBBLE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_HOLD  = 5'b11100;
  localparam logic [4:0] S_FLUSH = 5'b00011;

  bubble_ctrl #(.FLUSH_CYC(2), .MAX_STALL(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bb(bb), .br_taken(br_taken),
    .hold_s1(hold_s1), .hold_s2(hold_s2), .nop_s3(nop_s3),
    .flush_s1(flush_s1), .flush_s2(flush_s2),
    .stall_err(stall_err), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;
  assign st = {hold_s1, hold_s2, nop_s3, flush_s1, flush_s2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input int inc);
    ecnt = (ecnt + inc > 15) ? 15 : ecnt + inc;
  endtask

  function automatic logic [3:0] exp_cnt();
    return PERF ? 4'(ecnt) : 4'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; bb = 1'b0; br_taken = 1'b0;
    tick();
    rst = 1'b0;
    ecnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bb = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if (st !== S_NONE) begin
        n_bad++; $display("FAIL reset_strobes cyc%0d: got %b want %b", i, st, S_NONE);
      end
      tick();
    end
    rst = 1'b0; bb = 1'b0; br_taken = 1'b0;
    ecnt = 0;
    #2;
    n_cmp++;
    if (stall_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b want 0", stall_err);
    end
    n_cmp++;
    if (bubble_cnt !== 4'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt);
    end
    n_cmp++;
    if (st !== S_NONE) begin
      n_bad++; $display("FAIL reset_idle: got %b want %b", st, S_NONE);
    end
    tick();
  endtask

  task automatic test_single_stall();
    bb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (st !== S_HOLD) begin
        n_bad++; $display("FAIL stall_hold cyc%0d: got %b want %b", i, st, S_HOLD);
      end
      model_add(1);
      tick();
    end
    bb = 1'b0;
    #2;
    n_cmp++;
    if (st !== S_NONE) begin
      n_bad++; $display("FAIL stall_release: got %b want %b", st, S_NONE);
    end
    n_cmp++;
    if (bubble_cnt !== exp_cnt()) begin
      n_bad++; $display("FAIL stall_cnt: got %0d want %0d", bubble_cnt, exp_cnt());
    end
    tick();
  endtask

  task automatic test_branch();
    br_taken = 1'b1; bb = 1'b0;
    #2;
    n_cmp++;
    if (st !== S_FLUSH) begin
      n_bad++; $display("FAIL br_flush: got %b want %b", st, S_FLUSH);
    end
    model_add(2);
    tick();
    br_taken = 1'b0; bb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if (st !== S_NONE) begin
        n_bad++; $display("FAIL br_masked cyc%0d: got %b want %b", i, st, S_NONE);
      end
      tick();
    end
    #2;
    n_cmp++;
    if (st !== S_HOLD) begin
      n_bad++; $display("FAIL br_hold_after: got %b want %b", st, S_HOLD);
    end
    model_add(1);
    tick();
    bb = 1'b0;
    #2;
    n_cmp++;
    if (bubble_cnt !== exp_cnt()) begin
      n_bad++; $display("FAIL br_cnt: got %0d want %0d", bubble_cnt, exp_cnt());
    end
    tick();
  endtask

  task automatic test_simultaneous();
    bb = 1'b1; br_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model_add(1);
      tick();
    end
    br_taken = 1'b1;
    #2;
    n_cmp++;
    if (st !== S_FLUSH) begin
      n_bad++; $display("FAIL sim_flush_only: got %b want %b", st, S_FLUSH);
    end
    model_add(2);
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if (st !== S_NONE) begin
        n_bad++; $display("FAIL sim_masked cyc%0d: got %b want %b", i, st, S_NONE);
      end
      tick();
    end
    // stall_len restarts from 1: watchdog fires only after 8 fresh bb cycles
    for (int i = 1; i <= 9; i++) begin
      #2;
      n_cmp++;
      if (stall_err !== (i >= 9)) begin
        n_bad++; $display("FAIL sim_watchdog cyc%0d: got %b want %b", i, stall_err, (i >= 9));
      end
      model_add(1);
      tick();
    end
    bb = 1'b0;
    tick();
    #2;
    n_cmp++;
    if (bubble_cnt !== exp_cnt()) begin
      n_bad++; $display("FAIL sim_cnt_sat: got %0d want %0d", bubble_cnt, exp_cnt());
    end
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    #2;
    n_cmp++;
    if (stall_err !== 1'b0) begin
      n_bad++; $display("FAIL wd_cleared_by_rst: got %b want 0", stall_err);
    end
    bb = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      n_cmp++;
      if (stall_err !== (i >= 9)) begin
        n_bad++; $display("FAIL wd_edge cyc%0d: got %b want %b", i, stall_err, (i >= 9));
      end
      n_cmp++;
      if (st !== S_HOLD) begin
        n_bad++; $display("FAIL wd_hold cyc%0d: got %b want %b", i, st, S_HOLD);
      end
      tick();
    end
    bb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (stall_err !== 1'b1) begin
        n_bad++; $display("FAIL wd_sticky cyc%0d: got %b want 1", i, stall_err);
      end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    bb = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (st !== S_NONE) begin
      n_bad++; $display("FAIL rst_mid_strobes: got %b want %b", st, S_NONE);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2;
    n_cmp++;
    if (stall_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_stall_len: got %b want 0", stall_err);
    end
    bb = 1'b0; br_taken = 1'b1;
    tick();
    rst = 1'b1; br_taken = 1'b0;
    tick();
    rst = 1'b0; bb = 1'b1;
    #2;
    n_cmp++;
    if (st !== S_HOLD) begin
      n_bad++; $display("FAIL rst_mid_flush_run: got %b want %b", st, S_HOLD);
    end
    tick();
    bb = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      br_taken = 1'b1;
      model_add(2);
      tick();
      br_taken = 1'b0;
      #2;
      n_cmp++;
      if (bubble_cnt !== exp_cnt()) begin
        n_bad++; $display("FAIL sat_cnt pulse%0d: got %0d want %0d", k, bubble_cnt, exp_cnt());
      end
      tick();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; bb = 1'b0; br_taken = 1'b0;
    test_reset();
    test_single_stall();
    test_branch();
    test_simultaneous();
    test_watchdog();
    test_rst_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bubble_ctrl.md
# bubble_ctrl

Pipeline-side consumer of the hazard unit's bubble request for the 4-stage core (S1 fetch, S2 decode, S3 execute, S4 write-back). It turns `bb` and the stage-3 branch resolution into per-stage hold, NOP-inject and flush strobes. A small state machine masks stale hazard requests from wrong-path instructions after a taken branch. It also runs a stall watchdog and, optionally, a bubble performance counter.

## Interface
- `FLUSH_CYC`, 1: cycles `bb` stays masked after a taken-branch flush; legal range 1..3.
- `MAX_STALL`, 16: consecutive bubble cycles that raise `stall_err`; must be ≥2.
- `CNT_W`, 16: width of `bubble_cnt`.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bb`  in  1  bubble request from the hazard unit, valid every cycle.
- `br_taken`  in  1  taken branch/jump resolved in S3 this cycle.
- `hold_s1`  out  1  freeze PC and the S1/S2 register.
- `hold_s2`  out  1  freeze the S2/S3 register input (S2 instruction re-presented).
- `nop_s3`  out  1  load NOP into the S3 register.
- `flush_s1`  out  1  kill the S1 instruction (wrong path).
- `flush_s2`  out  1  kill the S2 instruction (wrong path).
- `stall_err`  out  1  sticky watchdog flag, registered.
- `bubble_cnt`  out  CNT_W  saturating bubble count, registered.

## Operation
- States are RUN, STALL and FLUSH. The counters are `fcnt` (2 b) and `stall_len` ($clog2(MAX_STALL+1) b).
- `br_taken` has priority over `bb` in every state.
- **br_taken = 1**, any state:
  - `flush_s1` = `flush_s2` = 1; hold and NOP outputs are 0.
  - Next state is FLUSH, `fcnt` ← FLUSH_CYC, `stall_len` ← 0.
- **RUN:**
  - `bb` = 1: `hold_s1` = `hold_s2` = `nop_s3` = 1, `stall_len` ← 1, next state STALL.
  - Otherwise all strobes are 0 and the state stays RUN.
- **STALL:**
  - `bb` = 1: hold/NOP strobes are 1 and `stall_len` ← min(`stall_len`+1, MAX_STALL).
  - If `stall_len`+1 == MAX_STALL, `stall_err` ← 1.
  - `bb` = 0: strobes are 0, `stall_len` ← 0, next state RUN.
- **FLUSH:**
  - `bb` is ignored and all strobes are 0.
  - Each cycle `fcnt` ← `fcnt`−1. When `fcnt` == 1 the next state is RUN.
  - The FLUSH state therefore lasts exactly FLUSH_CYC cycles.
  - A new `br_taken` in FLUSH re-flushes and reloads `fcnt`.
- `stall_err` is set only as above and clears only on `rst`.
- `bubble_cnt` update:
  - +1 in each cycle with `nop_s3` = 1.
  - +2 in each cycle with `flush_s1` = 1.
  - Computed in CNT_W+1 bits, saturating at 2^CNT_W−1.
- **Reset values:**
  - State RUN; `fcnt`, `stall_len` and `bubble_cnt` = 0; `stall_err` = 0.
  - While `rst` = 1, all strobes are forced to 0 regardless of `bb` and `br_taken`.

## Timing
- Strobes are Mealy outputs: combinational from the current state, `bb` and `br_taken`, with zero-cycle latency. They act in the same cycle as the request.
- State, counters, `stall_err` and `bubble_cnt` update on the rising edge of `clk`. `stall_err` and `bubble_cnt` reflect an event one cycle after it occurs.
- `bb` and `br_taken` in the same cycle: flush only, no hold. The held S2 instruction is on the wrong path.
- `rst` asserted mid-STALL or mid-FLUSH: the next cycle is RUN with all counters cleared. `stall_len` does not carry across the reset.
- `stall_len` saturates at MAX_STALL. `stall_err` does not toggle again after it is set.

## Configuration
- `BUBBLE_PERF_CNT_EN` defined: the `bubble_cnt` register and its adder are present, as described above.
- Not defined: `bubble_cnt` is tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `bb` = 1 and `br_taken` = 1 → all strobes 0 during reset. After release: RUN, `stall_err` = 0, `bubble_cnt` = 0.
- **Single stall:** `bb` = 1 for 3 cycles, then 0 → `hold_s1`/`hold_s2`/`nop_s3` high for exactly those 3 cycles, back in RUN, `bubble_cnt` = 3.
- **Taken branch with FLUSH_CYC = 2:** `br_taken` pulse, then `bb` = 1 for the next 3 cycles → `flush_s1`/`flush_s2` high 1 cycle, no hold in the 2 masked cycles, hold on the 3rd, `bubble_cnt` = 2+1 = 3.
- **Simultaneous `bb` and `br_taken`:** assert both in STALL → flush = 1 and hold = 0 that cycle, state FLUSH, `stall_len` cleared.
- **Watchdog with MAX_STALL = 8:** `bb` = 1 for 8 cycles → `stall_err` = 1 from the 9th cycle. It stays 1 after `bb` drops and clears only on `rst`.
- **Counter saturation, CNT_W = 4, macro defined:** 10 `br_taken` pulses spaced 3 cycles apart → `bubble_cnt` reaches 15 and holds. With the macro undefined → `bubble_cnt` = 0 throughout.
